// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32 controller: states, opcodes,
// ALU operation codes and datapath mux selects.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Branch condition from funct3 and the flags of rs1 - rs2.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic zero,
                                        input logic sign);
    case (funct3)
      3'b000:  return zero;   // beq
      3'b001:  return ~zero;  // bne
      3'b100:  return sign;   // blt
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps ALUOp plus instruction function bits to ALUControl.
module multicycle_controller_aludec
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // Only register-register sub sets funct7b5 meaningfully; addi must stay add.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-ALU, single-memory multi-cycle RV32 datapath.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Sign,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state_o
);

  state_t     state, next_state;
  logic [1:0] alu_op;
  logic       pcw_raw, irw_raw, mw_raw, rw_raw;

  // State register; the only storage in the controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= state_t'(RESET_STATE);
    else        state <= next_state;
  end

  // Next-state and Moore outputs; every output defaults to 0 / add.
  always_comb begin
    next_state = ST_FETCH;
    pcw_raw    = 1'b0;
    irw_raw    = 1'b0;
    mw_raw     = 1'b0;
    rw_raw     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state)
      ST_FETCH: begin
        // PC+4 computed in the ALU goes straight to PC as the IR loads.
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURES;
        irw_raw    = mem_ready;
        pcw_raw    = mem_ready;
        next_state = mem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        // Branch target OldPC+imm is latched into ALUOut speculatively.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next_state = ST_MEMADR;
          OP_RTYPE:     next_state = ST_EXECR;
          OP_ITYPE:     next_state = ST_EXECI;
          OP_BRANCH:    next_state = ST_BRANCH;
          OP_JAL:       next_state = ST_JAL;
          default:      next_state = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = op[5] ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = mem_ready ? ST_MEMWB : ST_MEMREAD;
      end
      ST_MEMWB: begin
        ResultSrc  = RES_DATA;
        rw_raw     = 1'b1;
        next_state = ST_FETCH;
      end
      ST_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mw_raw     = 1'b1;
        next_state = mem_ready ? ST_FETCH : ST_MEMWRITE;
      end
      ST_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        next_state = ST_ALUWB;
      end
      ST_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = ST_ALUWB;
      end
      ST_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        rw_raw     = 1'b1;
        next_state = ST_FETCH;
      end
      ST_BRANCH: begin
        // Compare rs1 - rs2; PC takes the target held in ALUOut when taken.
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        ResultSrc  = RES_ALUOUT;
        pcw_raw    = branch_taken(funct3, Zero, Sign);
        next_state = ST_FETCH;
      end
      ST_JAL: begin
        // PC <- target from ALUOut while the ALU forms OldPC+4 for rd.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALUOUT;
        pcw_raw    = 1'b1;
        next_state = ST_ALUWB;
      end
      default: next_state = ST_FETCH;
    endcase
  end

  // Immediate type depends only on the opcode, in every state.
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:     ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  // Enables are forced low while reset is asserted, even though FETCH
  // would otherwise follow mem_ready.
  assign PCWrite  = pcw_raw & rst_n;
  assign IRWrite  = irw_raw & rst_n;
  assign MemWrite = mw_raw  & rst_n;
  assign RegWrite = rw_raw  & rst_n;
  assign state_o  = state;

  multicycle_controller_aludec u_aludec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction expected cycle lists built from the
// instruction class, compared cycle by cycle against the controller outputs.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, Sign, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  int errors = 0;
  int checks = 0;

  multicycle_controller #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Sign(Sign), .mem_ready(mem_ready), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       mr, pcw, adr, mw, irw;
    logic [1:0] rs, sa, sb;
    logic       rw;
    logic [2:0] alu;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic s);
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    if (f3 == 3'd4) return s;
    return 1'b0;
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic pcw, input logic adr,
                      input logic mw, input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                      input logic [1:0] sb, input logic rw, input logic [2:0] alu);
    exp_t e;
    e.st = st; e.mr = mr; e.pcw = pcw; e.adr = adr; e.mw = mw; e.irw = irw;
    e.rs = rs; e.sa = sa; e.sb = sb; e.rw = rw; e.alu = alu;
    exp_q.push_back(e);
  endtask

  // Execute one instruction; fw / mw are the wait cycles in fetch / memory.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input logic s,
                           input int fw, input int mw);
    logic [19:0] got, want;
    logic [2:0]  fa;
    fa = funct_alu(o, f3, f7);
    exp_q.delete();
    for (int i = 0; i < fw; i++) push(ST_FETCH, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 3'b000);
    push(ST_FETCH, 1, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 3'b000);
    push(ST_DECODE, 1'($urandom), 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000);
    if (o == 7'b0000011) begin
      push(ST_MEMADR, 1'($urandom), 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000);
      for (int i = 0; i < mw; i++) push(ST_MEMREAD, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000);
      push(ST_MEMREAD, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000);
      push(ST_MEMWB, 1'($urandom), 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000);
    end else if (o == 7'b0100011) begin
      push(ST_MEMADR, 1'($urandom), 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000);
      for (int i = 0; i < mw; i++) push(ST_MEMWRITE, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000);
      push(ST_MEMWRITE, 1, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000);
    end else if (o == 7'b0110011) begin
      push(ST_EXECR, 1'($urandom), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, fa);
      push(ST_ALUWB, 1'($urandom), 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000);
    end else if (o == 7'b0010011) begin
      push(ST_EXECI, 1'($urandom), 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, fa);
      push(ST_ALUWB, 1'($urandom), 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000);
    end else if (o == 7'b1100011) begin
      push(ST_BRANCH, 1'($urandom), taken_of(f3, z, s), 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b001);
    end else if (o == 7'b1101111) begin
      push(ST_JAL, 1'($urandom), 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b000);
      push(ST_ALUWB, 1'($urandom), 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000);
    end
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; Sign = s;
    foreach (exp_q[i]) begin
      @(negedge clk);
      mem_ready = exp_q[i].mr;
      #1;
      want = {exp_q[i].st, exp_q[i].pcw, exp_q[i].adr, exp_q[i].mw, exp_q[i].irw,
              exp_q[i].rs, exp_q[i].sa, exp_q[i].sb, exp_q[i].rw, imm_of(o), exp_q[i].alu};
      got  = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
              RegWrite, ImmSrc, ALUControl};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs got %h, expected %h", name, i, got, want);
      end
    end
    // Instruction must have retired back to an idle fetch with no writes.
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({state_o, IRWrite, RegWrite, MemWrite} !== {ST_FETCH, 3'b000}) begin
      errors++;
      $display("FAIL %s retire: state/irw/rw/mw got %h, expected %h", name,
               {state_o, IRWrite, RegWrite, MemWrite}, {ST_FETCH, 3'b000});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op = OP_RTYPE; funct3 = 3'd0; funct7b5 = 1'b0;
    Zero = 1'b0; Sign = 1'b0;
    #2;
    checks++;
    if ({state_o, PCWrite, IRWrite, MemWrite, RegWrite} !== {ST_FETCH, 4'b0000}) begin
      errors++;
      $display("FAIL reset_initial: got %h, expected %h",
               {state_o, PCWrite, IRWrite, MemWrite, RegWrite}, {ST_FETCH, 4'b0000});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);  // FETCH -> DECODE -> EXECR
    #1;
    checks++;
    if (state_o !== ST_EXECR) begin
      errors++;
      $display("FAIL reset_reach_execr: state got %0d, expected %0d", state_o, ST_EXECR);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state_o, PCWrite, IRWrite, MemWrite, RegWrite} !== {ST_FETCH, 4'b0000}) begin
      errors++;
      $display("FAIL reset_async: got %h, expected %h",
               {state_o, PCWrite, IRWrite, MemWrite, RegWrite}, {ST_FETCH, 4'b0000});
    end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; op = 7'h7F;
    #1;
    checks++;
    if ({IRWrite, PCWrite, RegWrite} !== 3'b110) begin
      errors++;
      $display("FAIL reset_release_irw: irw/pcw/rw got %b, expected 110", {IRWrite, PCWrite, RegWrite});
    end
    @(negedge clk); #1;
    checks++;
    if (state_o !== ST_DECODE) begin
      errors++;
      $display("FAIL reset_first_edge: state got %0d, expected %0d", state_o, ST_DECODE);
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    checks++;
    if ({state_o, RegWrite, MemWrite} !== {ST_FETCH, 2'b00}) begin
      errors++;
      $display("FAIL reset_abandon: got %h, expected %h", {state_o, RegWrite, MemWrite}, {ST_FETCH, 2'b00});
    end
  endtask

  task automatic test_lw();
    run_instr("lw_wait2", OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 0, 2);
    run_instr("lw_fetchwait", OP_LW, 3'b010, 1'b1, 1'b1, 1'b1, 1, 0);
  endtask

  task automatic test_sw();
    run_instr("sw_ready", OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("sw_wait3", OP_SW, 3'b010, 1'b1, 1'b0, 1'b0, 0, 3);
  endtask

  task automatic test_alu_ops();
    run_instr("r_sub", OP_RTYPE, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr("r_add", OP_RTYPE, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("i_addi_f7", OP_ITYPE, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr("r_slt", OP_RTYPE, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("i_ori", OP_ITYPE, 3'b110, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("r_and", OP_RTYPE, 3'b111, 1'b0, 1'b0, 1'b0, 2, 0);
  endtask

  task automatic test_branches();
    run_instr("beq_z1", OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0);
    run_instr("bne_z1", OP_BRANCH, 3'b001, 1'b0, 1'b1, 1'b0, 0, 0);
    run_instr("blt_s1", OP_BRANCH, 3'b100, 1'b0, 1'b0, 1'b1, 0, 0);
    run_instr("br_f3_010", OP_BRANCH, 3'b010, 1'b0, 1'b1, 1'b1, 0, 0);
  endtask

  task automatic test_jal_unknown();
    run_instr("jal", OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr("unknown", 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, 7'b0110111};
    for (int n = 0; n < 40; n++) begin
      run_instr("random", ops[$urandom_range(0, 6)], 3'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu_ops();
    test_branches();
    test_jal_unknown();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM that sequences the shared-ALU, single-memory multi-cycle RV32 datapath: fetch, decode, execute, memory and writeback over several clocks.
- Drives mux selects, enables and ALU operation for the datapath, and the branch/jump PC-update decision.
- Memory accesses use a ready handshake so the unified memory may insert wait states.
- Sits beside the datapath top; replaces the single-cycle control unit for the multi-cycle core.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  instruction opcode from the IR.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- Zero  in  1  ALU result == 0.
- Sign  in  1  ALU result bit 31.
- mem_ready  in  1  memory completed the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR and OldPC enable.
- ResultSrc  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  SrcA: 00 PC, 01 OldPC, 10 rs1.
- ALUSrcB  out  2  SrcB: 00 rs2, 01 imm, 10 const 4.
- RegWrite  out  1  register file write enable.
- ImmSrc  out  2  immediate type: 00 I, 01 S, 10 B, 11 J.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- state_o  out  4  current state, for debug and bench.

Behaviour:
- State register is the only storage.
- On rst_n low, asynchronously:
  - state = FETCH.
  - All enables/strobes (PCWrite, IRWrite, MemWrite, RegWrite) are 0 while rst_n is low.
  - Reset mid-instruction abandons the instruction; no partial write is issued after release.
- Unlisted outputs are 0 in every state. ImmSrc is a combinational decode of op in every state (lw/I-type 00, sw 01, branch 10, jal 11, else 00).
- ALUOp (internal): 00 → add; 01 → sub; 10 → funct decode.
  - Funct decode: funct3 000 gives sub iff op[5] & funct7b5, else add. 010 → slt, 110 → or, 111 → and, others → add.
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
  - Next state by op: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; other → FETCH (treated as nop, no side effect).
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - Next: op[5]=0 → MEMREAD; op[5]=1 → MEMWRITE.
- MEMREAD: AdrSrc=1; hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
- MEMWRITE:
  - AdrSrc=1, MemWrite=1 (held high until mem_ready, inclusive).
  - Next FETCH on mem_ready.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; next ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
- BRANCH:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite = taken, where taken is: funct3 000 → Zero; 001 → ~Zero; 100 → Sign; other → 0.
  - Next FETCH.
- JAL:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 (PC ← target in ALUOut).
  - Next ALUWB (rd ← OldPC+4).
- Latency with zero wait states: lw 5, sw 4, R/I 4, branch 3, jal 4, unknown 2 cycles.
- Each extra mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Unused state encodings → FETCH on next edge.

Decomposition:
- Shared package holds:
  - State encodings (FETCH..JAL, 4-bit).
  - Opcode constants (LW, SW, RTYPE, ITYPE, BRANCH, JAL).
  - ALUOp codes.
  - ALUControl codes.
  - Mux-select constants for ResultSrc, ALUSrcA and ALUSrcB.
- One sub-module: the existing ALU decoder (ALUOp, funct3, funct7b5, op[5] → ALUControl), instantiated unchanged.
- FSM next-state and output logic live in this block.

Test Plan:
- Reset: rst_n=0 mid-EXECR → state_o=FETCH immediately; PCWrite, IRWrite, MemWrite, RegWrite = 0. Release with mem_ready=1 → IRWrite=1 on first edge.
- lw (op 0000011), mem_ready low 2 cycles in MEMREAD → states F,D,MA,MR,MR,MR,MWB; RegWrite=1 only in MWB with ResultSrc=01; 7 cycles total.
- sw (op 0100011), mem_ready=1 → MemWrite=1 exactly one cycle with AdrSrc=1; RegWrite never 1.
- R-type sub (funct3 000, funct7b5=1) → ALUControl=001 in EXECR; add (funct7b5=0) → 000. I-type addi with funct7b5=1 → 000.
- Branches:
  - beq with Zero=1 → PCWrite=1 in BRANCH.
  - bne with Zero=1 → PCWrite=0.
  - blt with Sign=1 → PCWrite=1.
  - funct3 010 → PCWrite=0.
- jal → PCWrite=1 in JAL, then RegWrite=1 in ALUWB. Unknown op 1111111 → FETCH after DECODE with no writes.
